// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op and FSM encodings plus a constant clog2 helper for logic_unit_pipe.
package logic_unit_pkg;
  typedef enum logic [2:0] {
    LU_AND  = 3'b000,
    LU_OR   = 3'b001,
    LU_XOR  = 3'b010,
    LU_NOR  = 3'b011,
    LU_ANDN = 3'b100,
    LU_ORN  = 3'b101,
    LU_XNOR = 3'b110,
    LU_OP7  = 3'b111
  } op_t;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CNT  = 1'b1
  } state_t;
  function automatic int lu_clog2(input int v);
    for (int r = 0; r < 31; r++) if ((1 << r) >= v) return r;
    return 31;
  endfunction
endpackage

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand beat in, result beat out, both valid/ready handshaked.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [2:0]       logicfn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] l_output;
  logic             zero;
  modport slave (
    input  in_valid, x, y, logicfn, out_ready,
    output in_ready, out_valid, l_output, zero
  );
  modport master (
    output in_valid, x, y, logicfn, out_ready,
    input  in_ready, out_valid, l_output, zero
  );
endinterface

// File: rtl/lu_popcnt_seq.sv
// lu_popcnt_seq: counts set bits of x one CHUNK per cycle; done is high in the last counting cycle.
module lu_popcnt_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int N  = WIDTH / CHUNK;
  localparam int AW = lu_clog2(WIDTH + 1);
  logic [WIDTH-1:0] shreg_q;
  logic [AW-1:0]    acc_q, cnt_q, pc;
  logic             busy_q;
  always_comb begin
    pc = '0;
    for (int i = 0; i < CHUNK; i++) pc = pc + AW'(shreg_q[i]);
  end
  assign done_o   = busy_q && cnt_q == AW'(N - 1);
  // acc never exceeds WIDTH, so AW bits always hold the final sum
  assign result_o = WIDTH'(acc_q + pc);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      shreg_q <= x_i;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (busy_q) begin
      busy_q  <= !done_o;
      shreg_q <= shreg_q >> CHUNK;
      acc_q   <= acc_q + pc;
      cnt_q   <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: handshaked 8-op bitwise unit with registered result.
// LOGIC_UNIT_POPCNT_EN makes op 111 a multi-cycle popcount of x; otherwise op 111 is NOT x.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);
  if (WIDTH < 8 || WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("logic_unit_pipe: WIDTH must be >= 8 and a multiple of CHUNK");
  end
  logic [WIDTH-1:0] op_res, pc_res, l_output_q, l_output_d;
  logic             out_valid_q, out_valid_d, zero_q;
  logic             idle, accept, pc_start, pc_done, load;
  assign bus.in_ready = idle && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
`ifdef LOGIC_UNIT_POPCNT_EN
  state_t state_q, state_d;
  assign idle     = state_q == ST_IDLE;
  assign pc_start = accept && op_t'(bus.logicfn) == LU_OP7;
  always_comb state_d = pc_start ? ST_CNT : (pc_done ? ST_IDLE : state_q);
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end
  lu_popcnt_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_popcnt (
    .clk      (clk),
    .rst      (rst),
    .start_i  (pc_start),
    .x_i      (bus.x),
    .done_o   (pc_done),
    .result_o (pc_res)
  );
`else
  assign idle     = 1'b1;
  assign pc_start = 1'b0;
  assign pc_done  = 1'b0;
  assign pc_res   = '0;
`endif
  // op 111 falls to NOT x; under popcount it is never loaded from here
  always_comb begin
    case (op_t'(bus.logicfn))
      LU_AND:  op_res = bus.x & bus.y;
      LU_OR:   op_res = bus.x | bus.y;
      LU_XOR:  op_res = bus.x ^ bus.y;
      LU_NOR:  op_res = ~(bus.x | bus.y);
      LU_ANDN: op_res = bus.x & ~bus.y;
      LU_ORN:  op_res = bus.x | ~bus.y;
      LU_XNOR: op_res = ~(bus.x ^ bus.y);
      default: op_res = ~bus.x;
    endcase
  end
  assign load        = (accept && !pc_start) || pc_done;
  assign l_output_d  = pc_done ? pc_res : op_res;
  assign out_valid_d = load || (out_valid_q && !bus.out_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      l_output_q  <= '0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        l_output_q <= l_output_d;
        zero_q     <= ~|l_output_d;
      end
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.l_output  = l_output_q;
  assign bus.zero      = zero_q;
endmodule
